// File: rtl/feature_streamer.sv
// Buffers one frame of features from a valid/ready byte source, replays them to the
// inference core as index/data/start strobes, then waits (with a watchdog) for the result.
module feature_streamer #(
   parameter int NUM_FEATURES = 136,
   parameter int DATA_W       = 8,
   parameter int IDX_W        = 8,
   parameter int TIMEOUT      = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              ds_start,
   output logic [IDX_W-1:0]  ds_index,
   output logic [DATA_W-1:0] ds_data,
   input  logic [DATA_W-1:0] ds_out_data,
   input  logic              ds_done,
   output logic              result_valid,
   output logic [DATA_W-1:0] result_data,
   output logic              result_err,
   input  logic              result_ack,
   output logic              busy
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {S_LOAD, S_SEND, S_GAP, S_WAIT, S_RESULT} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [IDX_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [IDX_W-1:0]  rd_next;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [DATA_W-1:0] ds_data_q, ds_data_d;
   logic [DATA_W-1:0] result_data_q, result_data_d;
   logic              result_err_q, result_err_d;
   logic              wr_fire;

   // Feature buffer: no reset, every entry is rewritten before it is replayed.
   logic [DATA_W-1:0] feat_mem_q [NUM_FEATURES];

   assign wr_fire = (state_q == S_LOAD) && wr_valid;
   assign rd_next = rd_ptr_q + IDX_W'(1);

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         feat_mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_LOAD;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         wd_q          <= '0;
         ds_data_q     <= '0;
         result_data_q <= '0;
         result_err_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         wd_q          <= wd_d;
         ds_data_q     <= ds_data_d;
         result_data_q <= result_data_d;
         result_err_q  <= result_err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      wd_d          = wd_q;
      ds_data_d     = ds_data_q;
      result_data_d = result_data_q;
      result_err_d  = result_err_q;
      case (state_q)
         S_LOAD: begin
            if (wr_valid) begin
               if (wr_ptr_q == LAST_IDX) begin
                  wr_ptr_d  = '0;
                  rd_ptr_d  = '0;
                  ds_data_d = feat_mem_q[0];
                  state_d   = S_SEND;
               end else begin
                  wr_ptr_d = wr_ptr_q + IDX_W'(1);
               end
            end
         end
         S_SEND: begin
            state_d = S_GAP;
         end
         S_GAP: begin
            if (rd_ptr_q == LAST_IDX) begin
               wd_d    = '0;
               state_d = S_WAIT;
            end else begin
               // Data is fetched on the way into SEND so it is registered when the strobe rises.
               rd_ptr_d  = rd_next;
               ds_data_d = feat_mem_q[rd_next];
               state_d   = S_SEND;
            end
         end
         S_WAIT: begin
            wd_d = wd_q + WD_W'(1);
            if (ds_done) begin
               result_data_d = ds_out_data;
               result_err_d  = 1'b0;
               state_d       = S_RESULT;
            end else if (wd_q == WD_LAST) begin
               result_data_d = '0;
               result_err_d  = 1'b1;
               state_d       = S_RESULT;
            end
         end
         S_RESULT: begin
            if (result_ack) begin
               result_err_d = 1'b0;
               state_d      = S_LOAD;
            end
         end
         default: begin
            state_d = S_LOAD;
         end
      endcase
   end

   always_comb begin
      wr_ready     = (state_q == S_LOAD);
      ds_start     = (state_q == S_SEND);
      busy         = (state_q != S_LOAD);
      result_valid = (state_q == S_RESULT);
      ds_index     = rd_ptr_q;
      ds_data      = ds_data_q;
      result_data  = result_data_q;
      result_err   = result_err_q;
   end

endmodule

// File: tb/tb_feature_streamer.sv
// Directed bench for feature_streamer: frame loading, strobe replay, done capture,
// watchdog expiry, mid-stream reset and permanently asserted acknowledge.
module tb_feature_streamer;

   localparam int NF = 136;
   localparam int DW = 8;
   localparam int IW = 8;
   localparam int TO = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_valid;
   logic          wr_ready;
   logic [DW-1:0] wr_data;
   logic          ds_start;
   logic [IW-1:0] ds_index;
   logic [DW-1:0] ds_data;
   logic [DW-1:0] ds_out_data;
   logic          ds_done;
   logic          result_valid;
   logic [DW-1:0] result_data;
   logic          result_err;
   logic          result_ack;
   logic          busy;

   feature_streamer #(
      .NUM_FEATURES (NF),
      .DATA_W       (DW),
      .IDX_W        (IW),
      .TIMEOUT      (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_data      (wr_data),
      .ds_start     (ds_start),
      .ds_index     (ds_index),
      .ds_data      (ds_data),
      .ds_out_data  (ds_out_data),
      .ds_done      (ds_done),
      .result_valid (result_valid),
      .result_data  (result_data),
      .result_err   (result_err),
      .result_ack   (result_ack),
      .busy         (busy)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: {index, data} per expected strobe, in order
   logic [15:0] exp_q[$];
   bit          frame_loaded = 1'b0;
   int          n_strobes = 0;
   int          last_strobe_cyc = 0;
   bit          prev_start = 1'b0;
   logic [7:0]  prev_idx;
   logic [7:0]  prev_data;
   logic [15:0] mon_e;

   always @(negedge clk) begin
      if (!rst && ds_start) begin
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", 32'(ds_index), 32'hFFFF);
         end else begin
            mon_e = exp_q.pop_front();
            check("ds_index", 32'(ds_index), 32'(mon_e[15:8]));
            check("ds_data", 32'(ds_data), 32'(mon_e[7:0]));
            if (mon_e[15:8] != 8'd0) check("strobe_spacing", 32'(cyc - last_strobe_cyc), 32'd2);
         end
         check("strobe_after_load", 32'(frame_loaded), 32'd1);
         last_strobe_cyc = cyc;
         n_strobes++;
      end else if (!rst && prev_start) begin
         check("gap_index_hold", 32'(ds_index), 32'(prev_idx));
         check("gap_data_hold", 32'(ds_data), 32'(prev_data));
      end
      prev_start = ds_start && !rst;
      prev_idx   = ds_index;
      prev_data  = ds_data;
   end

   // Driver tasks
   task automatic send_frame(input bit ramp, input logic [7:0] fill, input bit gaps);
      frame_loaded = 1'b0;
      n_strobes    = 0;
      for (int i = 0; i < NF; i++) begin
         logic [7:0] d;
         int g;
         int b;
         d = ramp ? 8'(i) : fill;
         g = gaps ? int'($urandom_range(0, 3)) : 0;
         if (g > 0) begin
            wr_valid = 1'b0;
            repeat (g) @(posedge clk);
            #1;
         end
         wr_valid = 1'b1;
         wr_data  = d;
         b = 0;
         while (!wr_ready && b < 50) begin
            @(posedge clk);
            #1;
            b++;
         end
         if (!wr_ready) begin
            check("wr_ready_timeout", 32'd0, 32'd1);
            break;
         end
         exp_q.push_back({8'(i), d});
         @(posedge clk);
         #1;
      end
      wr_valid     = 1'b0;
      wr_data      = 8'hEE;
      frame_loaded = 1'b1;
   endtask

   task automatic wait_index(input logic [7:0] idx);
      int  b;
      bit  found;
      b = 0;
      found = 1'b0;
      while (!found && b < 2000) begin
         @(negedge clk);
         b++;
         found = ds_start && (ds_index == idx);
      end
      if (!found) check("strobe_wait_timeout", 32'(idx), 32'hFFFF);
   endtask

   // Called at the negedge of the last strobe; pulses done 'delay' cycles later
   task automatic core_done(input int delay, input logic [7:0] val);
      repeat (delay) @(posedge clk);
      #1;
      check("result_not_early", 32'(result_valid), 32'd0);
      ds_done     = 1'b1;
      ds_out_data = val;
      @(posedge clk);
      #1;
      ds_done     = 1'b0;
      ds_out_data = 8'hC6;
      @(negedge clk);
   endtask

   task automatic check_result(input logic [7:0] data, input bit err);
      check("result_valid", 32'(result_valid), 32'd1);
      check("result_data", 32'(result_data), 32'(data));
      check("result_err", 32'(result_err), 32'(err));
      check("result_busy", 32'(busy), 32'd1);
      check("result_wr_ready", 32'(wr_ready), 32'd0);
   endtask

   task automatic check_back_in_load();
      check("load_wr_ready", 32'(wr_ready), 32'd1);
      check("load_result_valid", 32'(result_valid), 32'd0);
      check("load_result_err", 32'(result_err), 32'd0);
      check("load_busy", 32'(busy), 32'd0);
   endtask

   task automatic ack_result();
      result_ack = 1'b1;
      @(posedge clk);
      #1;
      result_ack = 1'b0;
      @(negedge clk);
      check_back_in_load();
   endtask

   task automatic end_frame_checks();
      check("strobe_count", 32'(n_strobes), 32'(NF));
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst         = 1'b1;
      wr_valid    = 1'b0;
      wr_data     = 8'h00;
      ds_out_data = 8'hC6;
      ds_done     = 1'b0;
      result_ack  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_wr_ready", 32'(wr_ready), 32'd1);
      check("rst_ds_start", 32'(ds_start), 32'd0);
      check("rst_ds_index", 32'(ds_index), 32'd0);
      check("rst_ds_data", 32'(ds_data), 32'd0);
      check("rst_result_valid", 32'(result_valid), 32'd0);
      check("rst_result_data", 32'(result_data), 32'd0);
      check("rst_result_err", 32'(result_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      // Constant frame, wr_valid held high, done 10 cycles after last strobe
      @(posedge clk);
      #1;
      send_frame(1'b0, 8'h7F, 1'b0);
      wait_index(8'd135);
      core_done(10, 8'h5A);
      check_result(8'h5A, 1'b0);
      end_frame_checks();
      ack_result();

      // Ramp frame with random source gaps
      send_frame(1'b1, 8'h00, 1'b1);
      wait_index(8'd135);
      core_done(3, 8'hC3);
      check_result(8'hC3, 1'b0);
      end_frame_checks();
      ack_result();

      // Early done during SEND of index 40 must be ignored
      send_frame(1'b0, 8'h11, 1'b0);
      wait_index(8'd40);
      ds_done     = 1'b1;
      ds_out_data = 8'hEE;
      @(posedge clk);
      #1;
      ds_done     = 1'b0;
      ds_out_data = 8'hC6;
      wait_index(8'd135);
      core_done(5, 8'h33);
      check_result(8'h33, 1'b0);
      end_frame_checks();
      ack_result();

      // Watchdog: WAIT entered 2 cycles after the last strobe, expiry 64 cycles later
      send_frame(1'b0, 8'h3C, 1'b0);
      wait_index(8'd135);
      repeat (65) @(negedge clk);
      check("wd_not_early", 32'(result_valid), 32'd0);
      @(negedge clk);
      check_result(8'h00, 1'b1);
      end_frame_checks();
      ack_result();

      // Reset while index 50 is on the bus
      send_frame(1'b1, 8'h00, 1'b0);
      wait_index(8'd50);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_ds_start", 32'(ds_start), 32'd0);
      check("rst_mid_wr_ready", 32'(wr_ready), 32'd1);
      check("rst_mid_ds_index", 32'(ds_index), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      exp_q.delete();
      send_frame(1'b0, 8'h96, 1'b0);
      wait_index(8'd135);
      core_done(6, 8'h77);
      check_result(8'h77, 1'b0);
      end_frame_checks();
      ack_result();

      // result_ack held high across two frames: one-cycle results
      result_ack = 1'b1;
      send_frame(1'b0, 8'h21, 1'b0);
      wait_index(8'd135);
      core_done(4, 8'h21);
      check_result(8'h21, 1'b0);
      @(negedge clk);
      check_back_in_load();
      end_frame_checks();
      send_frame(1'b1, 8'h00, 1'b1);
      wait_index(8'd135);
      core_done(3, 8'h42);
      check_result(8'h42, 1'b0);
      @(negedge clk);
      check_back_in_load();
      end_frame_checks();
      result_ack = 1'b0;

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got 0 expected 1");
      $fatal(1, "bench time limit reached");
   end

endmodule
